rpt_add_multiplier: RTL

Parametrised sequential multiplier built from repeated addition: a controller FSM drives a datapath made of an accumulator, a loop counter, an adder and a zero comparator. It is the width-generic successor of the fixed 16-bit add-and-decrement multiplier, with these additions:
- signed or unsigned mode per transaction
- operand swap, so the loop count equals the smaller magnitude
- start/busy/done handshake and synchronous abort
- full-width product, so there is no truncation

It sits as a standalone arithmetic unit behind a simple request/response handshake.

---
 rtl/rpt_mul_pkg.sv | 16 +
 rtl/rpt_mul_datapath.sv | 95 +++++++++
 rtl/rpt_add_multiplier.sv | 114 +++++++++++
 3 files changed

// File: rtl/rpt_mul_pkg.sv
// rpt_mul_pkg
//   Shared definitions for the repeated-addition multiplier:
//   controller state encoding and its width.
package rpt_mul_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/rpt_mul_datapath.sv
// rpt_mul_datapath
//   Registers and arithmetic for the repeated-addition multiplier.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     capture           latch a_in/b_in/is_signed (request accepted)
//     load, clear       load adder/counter/sign from magnitudes, clear accumulator
//     add, dec          one loop step: acc += adder, counter -= 1
//     fix               write signed-corrected accumulator into product
//     is_signed, a_in, b_in  request operands
//     cnt_zero          counter value after this cycle's update is zero
//     product           2*WIDTH-bit result register
module rpt_mul_datapath #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               capture,
  input  logic               load,
  input  logic               clear,
  input  logic               add,
  input  logic               dec,
  input  logic               fix,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               cnt_zero,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   a_q, b_q;
  logic               sgn_q;
  logic [WIDTH-1:0]   adder_q;
  logic [WIDTH-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   mag_a, mag_b, mag_max, mag_min;
  logic               neg_nxt;
  logic [WIDTH-1:0]   cnt_nxt;

  // Unary minus on the most negative value wraps to itself, which read as
  // unsigned is exactly 2^(WIDTH-1), so the magnitude is still correct.
  assign mag_a   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b   = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
  assign mag_max = (mag_a >= mag_b) ? mag_a : mag_b;
  assign mag_min = (mag_a >= mag_b) ? mag_b : mag_a;
  assign neg_nxt = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);

  // Zero compare looks at the value the counter is about to take, so the
  // controller can leave LOAD/RUN on the same edge the counter hits zero.
  always_comb begin
    cnt_nxt = cnt_q;
    if (load)
      cnt_nxt = mag_min;
    else if (dec)
      cnt_nxt = cnt_q - WIDTH'(1);
  end

  assign cnt_zero = (cnt_nxt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      adder_q   <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      if (capture) begin
        a_q   <= a_in;
        b_q   <= b_in;
        sgn_q <= is_signed;
      end
      if (load) begin
        adder_q <= mag_max;
        neg_q   <= neg_nxt;
      end
      if (load || dec)
        cnt_q <= cnt_nxt;
      if (clear)
        acc_q <= '0;
      else if (add)
        acc_q <= acc_q + {{WIDTH{1'b0}}, adder_q};
      if (fix)
        product_q <= neg_q ? -acc_q : acc_q;
    end
  end

  assign product = product_q;

endmodule

// File: rtl/rpt_add_multiplier.sv
// rpt_add_multiplier
//   Sequential multiplier by repeated addition; loop count is the smaller
//   operand magnitude. Signed/unsigned per request, synchronous abort.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     start             request, honoured only when idle
//     is_signed         two's-complement operands (sampled with start)
//     a_in, b_in        operands (sampled with start)
//     abort             cancel an in-flight operation (LOAD/RUN/FIX)
//     busy              high whenever not idle
//     done              one-cycle pulse, product valid
//     product           full 2*WIDTH-bit result, held until next request
//
//   state  | meaning
//   IDLE   | waiting for start; operands latched on accept
//   LOAD   | magnitudes/sign formed, adder=max, counter=min, acc cleared
//   RUN    | one add + counter decrement per cycle
//   FIX    | apply sign to accumulator into product
//   DONE   | done pulse, return to IDLE
module rpt_add_multiplier
  import rpt_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t state_q, state_nxt;
  logic   capture, load, clear, add, dec, fix;
  logic   cnt_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_nxt;
  end

  // abort wins over loop progress: no strobes are issued on an aborted cycle.
  always_comb begin
    state_nxt = state_q;
    capture   = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;
    add       = 1'b0;
    dec       = 1'b0;
    fix       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          load      = 1'b1;
          clear     = 1'b1;
          state_nxt = cnt_zero ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          add       = 1'b1;
          dec       = 1'b1;
          state_nxt = cnt_zero ? S_FIX : S_RUN;
        end
      end
      S_FIX: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          fix       = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  rpt_mul_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture),
    .load      (load),
    .clear     (clear),
    .add       (add),
    .dec       (dec),
    .fix       (fix),
    .is_signed (is_signed),
    .a_in      (a_in),
    .b_in      (b_in),
    .cnt_zero  (cnt_zero),
    .product   (product)
  );

endmodule
